// File: rtl/button_array_controller.sv
// Multi-channel button debouncer with press/release pulses, auto-repeat,
// held/long-press levels and a lowest-index press encoder.
module button_array_controller #(
   parameter int CHANNELS        = 4,
   parameter int DEBOUNCE_CYCLES = 10000,
   parameter int REPEAT_DELAY    = 5000000,
   parameter int REPEAT_PERIOD   = 1000000,
   parameter int LONG_CYCLES     = 20000000,
   parameter int CNT_W           = 26,
   parameter int IDX_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] button_n,
   input  logic [CHANNELS-1:0] repeat_en,
   output logic [CHANNELS-1:0] press_pulse,
   output logic [CHANNELS-1:0] release_pulse,
   output logic [CHANNELS-1:0] held,
   output logic [CHANNELS-1:0] long_press,
   output logic                any_event,
   output logic [IDX_W-1:0]    event_idx
);

   localparam logic [1:0] S_INIT  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_HELD  = 2'd2;

   localparam logic [CNT_W-1:0] L_DEB    = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] L_DELAY  = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] L_PER_M1 = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [CNT_W-1:0] L_LONG   = CNT_W'(LONG_CYCLES);

   logic [CHANNELS-1:0] w_press;
   logic [CHANNELS-1:0] w_release;
   logic [CHANNELS-1:0] w_held;
   logic [CHANNELS-1:0] w_long;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic             r_s1;
      logic             r_s2;
      logic [1:0]       r_state;
      logic [CNT_W-1:0] r_rel_cnt;
      logic [CNT_W-1:0] r_hold_cnt;
      logic [CNT_W-1:0] r_rep_cnt;
      logic             r_rep_on;
      logic             r_press;
      logic             r_release;
      logic             r_held;
      logic             r_long;
      logic [CNT_W-1:0] w_rel_nxt;
      logic [CNT_W-1:0] w_hold_nxt;
      logic             w_rel_done;
      logic             w_due;

      assign w_rel_nxt  = r_rel_cnt + 1'b1;
      assign w_rel_done = r_s2 && (w_rel_nxt == L_DEB);
      assign w_hold_nxt = (&r_hold_cnt) ? r_hold_cnt : r_hold_cnt + 1'b1;
      // Schedule keeps ticking even when the pulse itself is suppressed
      assign w_due = r_rep_on ? (r_rep_cnt == L_PER_M1)
                              : (w_hold_nxt == L_DELAY);

      always_ff @(posedge clk) begin
         if (reset) begin
            r_s1       <= 1'b1;
            r_s2       <= 1'b1;
            r_state    <= S_INIT;
            r_rel_cnt  <= '0;
            r_hold_cnt <= '0;
            r_rep_cnt  <= '0;
            r_rep_on   <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_held     <= 1'b0;
            r_long     <= 1'b0;
         end else begin
            r_s1      <= button_n[g];
            r_s2      <= r_s1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
               S_INIT: begin
                  if (!r_s2) begin
                     r_rel_cnt <= '0;
                  end else if (w_rel_done) begin
                     r_rel_cnt <= '0;
                     r_state   <= S_ARMED;
                  end else begin
                     r_rel_cnt <= w_rel_nxt;
                  end
               end
               S_ARMED: begin
                  if (!r_s2) begin
                     r_press    <= 1'b1;
                     r_held     <= 1'b1;
                     r_hold_cnt <= '0;
                     r_rep_cnt  <= '0;
                     r_rel_cnt  <= '0;
                     r_rep_on   <= 1'b0;
                     r_state    <= S_HELD;
                  end
               end
               S_HELD: begin
                  r_hold_cnt <= w_hold_nxt;
                  if (w_hold_nxt >= L_LONG) r_long <= 1'b1;
                  if (w_due) begin
                     r_rep_on  <= 1'b1;
                     r_rep_cnt <= '0;
                  end else if (r_rep_on) begin
                     r_rep_cnt <= r_rep_cnt + 1'b1;
                  end
                  if (w_due && repeat_en[g] && !r_s2 && !r_press)
                     r_press <= 1'b1;
                  if (!r_s2) begin
                     r_rel_cnt <= '0;
                  end else if (w_rel_done) begin
                     r_release <= 1'b1;
                     r_held    <= 1'b0;
                     r_long    <= 1'b0;
                     r_rel_cnt <= '0;
                     r_state   <= S_ARMED;
                  end else begin
                     r_rel_cnt <= w_rel_nxt;
                  end
               end
               default: r_state <= S_INIT;
            endcase
         end
      end

      assign w_press[g]   = r_press;
      assign w_release[g] = r_release;
      assign w_held[g]    = r_held;
      assign w_long[g]    = r_long;
   end

   assign press_pulse   = w_press;
   assign release_pulse = w_release;
   assign held          = w_held;
   assign long_press    = w_long;
   assign any_event     = |w_press;

   // Scan downward so the lowest active index is the last one written
   always_comb begin
      event_idx = '0;
      for (int i = CHANNELS - 1; i >= 0; i--)
         if (w_press[i]) event_idx = IDX_W'(i);
   end

endmodule

// File: tb/tb_button_array_controller.sv
// Directed self-checking bench for button_array_controller.
// Inputs change 1 time unit after a rising edge; outputs sampled there too.
module tb_button_array_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] button_n = 4'hF;
   logic [3:0] repeat_en = 4'h0;
   logic [3:0] press_pulse;
   logic [3:0] release_pulse;
   logic [3:0] held;
   logic [3:0] long_press;
   logic       any_event;
   logic [1:0] event_idx;

   int checks = 0;
   int failures = 0;

   button_array_controller #(
      .CHANNELS(4),
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY(10),
      .REPEAT_PERIOD(5),
      .LONG_CYCLES(20),
      .CNT_W(26)
   ) dut (
      .clk(clk),
      .reset(reset),
      .button_n(button_n),
      .repeat_en(repeat_en),
      .press_pulse(press_pulse),
      .release_pulse(release_pulse),
      .held(held),
      .long_press(long_press),
      .any_event(any_event),
      .event_idx(event_idx)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++;
      if ({press_pulse, release_pulse, held, long_press} !== 16'h0
          || any_event !== 1'b0 || event_idx !== 2'd0) begin
         failures++;
         $display("FAIL reset_outputs: got pp=%b rp=%b h=%b lp=%b ae=%b idx=%0d want all 0",
                  press_pulse, release_pulse, held, long_press, any_event, event_idx);
      end
      reset = 1'b0;
      for (int i = 0; i < 6; i++) step();
   endtask

   task automatic test_press_latency();
      button_n[1] = 1'b0;
      step();
      checks++;
      if (press_pulse !== 4'b0000) begin
         failures++;
         $display("FAIL press_N: got %b want 0000", press_pulse);
      end
      step();
      checks++;
      if (press_pulse !== 4'b0000) begin
         failures++;
         $display("FAIL press_N1: got %b want 0000", press_pulse);
      end
      step();
      checks++;
      if (press_pulse !== 4'b0010 || held[1] !== 1'b1
          || event_idx !== 2'd1 || any_event !== 1'b1) begin
         failures++;
         $display("FAIL press_N2: got pp=%b h=%b idx=%0d ae=%b want 0010 1 1 1",
                  press_pulse, held[1], event_idx, any_event);
      end
      step();
      checks++;
      if (press_pulse !== 4'b0000 || held[1] !== 1'b1) begin
         failures++;
         $display("FAIL press_N3: got pp=%b h=%b want 0000 1", press_pulse, held[1]);
      end
   endtask

   task automatic test_bounce_release();
      logic [8:0] seq;
      seq = 9'b111101101;
      for (int k = 0; k < 16; k++) begin
         button_n[1] = (k < 9) ? seq[k] : 1'b1;
         step();
         checks++;
         if (press_pulse !== 4'b0000 || release_pulse[1] !== (k == 10)) begin
            failures++;
            $display("FAIL bounce_k%0d: got pp=%b rp1=%b want 0000 %b",
                     k, press_pulse, release_pulse[1], (k == 10));
         end
      end
      checks++;
      if (held[1] !== 1'b0) begin
         failures++;
         $display("FAIL bounce_held: got %b want 0", held[1]);
      end
   endtask

   task automatic test_repeat_long();
      logic exp_p;
      repeat_en[0] = 1'b1;
      button_n[0] = 1'b0;
      step();
      step();
      step();
      checks++;
      if (press_pulse[0] !== 1'b1) begin
         failures++;
         $display("FAIL repeat_first: got %b want 1", press_pulse[0]);
      end
      for (int k = 1; k <= 40; k++) begin
         if (k == 31) button_n[0] = 1'b1;
         step();
         exp_p = (k == 10 || k == 15 || k == 20 || k == 25 || k == 30);
         checks++;
         if (press_pulse[0] !== exp_p || long_press[0] !== (k >= 20 && k < 36)
             || release_pulse[0] !== (k == 36)) begin
            failures++;
            $display("FAIL repeat_k%0d: got pp=%b lp=%b rp=%b want %b %b %b",
                     k, press_pulse[0], long_press[0], release_pulse[0],
                     exp_p, (k >= 20 && k < 36), (k == 36));
         end
      end
      repeat_en[0] = 1'b0;
   endtask

   task automatic test_simultaneous();
      button_n[3:2] = 2'b00;
      step();
      step();
      step();
      checks++;
      if (press_pulse !== 4'b1100 || event_idx !== 2'd2 || any_event !== 1'b1) begin
         failures++;
         $display("FAIL simul_press: got pp=%b idx=%0d ae=%b want 1100 2 1",
                  press_pulse, event_idx, any_event);
      end
      step();
      checks++;
      if (press_pulse !== 4'b0000 || any_event !== 1'b0 || event_idx !== 2'd0) begin
         failures++;
         $display("FAIL simul_after: got pp=%b ae=%b idx=%0d want 0000 0 0",
                  press_pulse, any_event, event_idx);
      end
      button_n = 4'hF;
      for (int i = 0; i < 10; i++) step();
   endtask

   task automatic test_powerup_held();
      int npress;
      button_n[0] = 1'b0;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (press_pulse !== 4'b0000 || held !== 4'b0000) begin
            failures++;
            $display("FAIL powerup_c%0d: got pp=%b h=%b want 0000 0000",
                     i, press_pulse, held);
         end
      end
      button_n[0] = 1'b1;
      for (int i = 0; i < 8; i++) step();
      button_n[0] = 1'b0;
      npress = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (press_pulse[0]) npress++;
      end
      checks++;
      if (npress !== 1 || held[0] !== 1'b1) begin
         failures++;
         $display("FAIL powerup_press: got pulses=%0d held=%b want 1 1", npress, held[0]);
      end
   endtask

   task automatic test_reset_mid_hold();
      for (int i = 0; i < 15; i++) step();
      checks++;
      if (long_press[0] !== 1'b1) begin
         failures++;
         $display("FAIL midrst_long: got %b want 1", long_press[0]);
      end
      reset = 1'b1;
      step();
      checks++;
      if ({press_pulse, release_pulse, held, long_press} !== 16'h0 || any_event !== 1'b0) begin
         failures++;
         $display("FAIL midrst_outputs: got pp=%b rp=%b h=%b lp=%b want all 0",
                  press_pulse, release_pulse, held, long_press);
      end
      reset = 1'b0;
      button_n[0] = 1'b1;
      for (int i = 0; i < 15; i++) begin
         step();
         checks++;
         if (release_pulse !== 4'b0000 || press_pulse !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_c%0d: got rp=%b pp=%b want 0000 0000",
                     i, release_pulse, press_pulse);
         end
      end
   endtask

   initial begin
      test_reset();
      test_press_latency();
      test_bounce_release();
      test_repeat_long();
      test_simultaneous();
      test_powerup_held();
      test_reset_mid_hold();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/button_array_controller.md
Name: button_array_controller

Overview:
Multi-channel successor to the single-button press controller. Debounces CHANNELS active-low button inputs and emits one-cycle active-high press pulses. Adds optional per-channel auto-repeat, debounced release pulses, debounced held and long-press levels, and a lowest-index event encoder. Sits between the board button pins and the control FSMs, such as mode selection and ROM paging.

Parameters:
CHANNELS, 4, number of independent button channels (>=1)
DEBOUNCE_CYCLES, 10000, consecutive stable-released cycles required to arm a press and to confirm a release (>=1)
REPEAT_DELAY, 5000000, cycles from the initial press pulse to the first auto-repeat pulse (>=1)
REPEAT_PERIOD, 1000000, cycles between subsequent auto-repeat pulses (>=1)
LONG_CYCLES, 20000000, hold cycles after the press pulse before long_press asserts (>=1)
CNT_W, 26, width of every internal counter; all cycle parameters must be < 2^CNT_W

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
button_n  in  CHANNELS  raw button pins, active low (0 = pressed), asynchronous
repeat_en  in  CHANNELS  per-channel auto-repeat enable, sampled every cycle
press_pulse  out  CHANNELS  one-cycle pulse on the initial press and on each auto-repeat
release_pulse  out  CHANNELS  one-cycle pulse on a confirmed release
held  out  CHANNELS  debounced pressed level
long_press  out  CHANNELS  level; channel held >= LONG_CYCLES
any_event  out  1  OR of press_pulse
event_idx  out  max($clog2(CHANNELS),1)  index of the lowest-numbered channel with press_pulse high; 0 when none

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high.
- Reset values:
  - All outputs 0.
  - Per-channel synchronizer flops set to 1 (released).
  - All counters 0; every channel FSM goes to INIT.
- Synchronizer: two-flop synchronizer per channel; the FSM acts on stage 2 (s).
- Press latency: if button_n[i] is first sampled low at edge N, press_pulse[i] is high from edge N+2 to edge N+3, provided the channel was ARMED.
- Per-channel FSM, channels fully independent:
  - INIT: rel_cnt counts consecutive s=1 cycles; any s=0 clears it. When rel_cnt reaches DEBOUNCE_CYCLES, go to ARMED. No release_pulse is emitted.
  - ARMED: on s=0, assert press_pulse for one cycle, set held=1, clear hold_cnt, rep_cnt and rel_cnt, go to HELD.
  - HELD:
    - hold_cnt increments every cycle, saturating at 2^CNT_W-1.
    - s=1 increments rel_cnt; s=0 clears it.
    - When rel_cnt reaches DEBOUNCE_CYCLES: assert release_pulse for one cycle, clear held and long_press, go to ARMED.
- Bounce handling: low glitches during a release debounce only restart rel_cnt. They never produce a second press_pulse.
- Auto-repeat, HELD only, while repeat_en[i]=1:
  - First repeat press_pulse fires when hold_cnt == REPEAT_DELAY.
  - Further repeats fire every REPEAT_PERIOD cycles after that, tracked by rep_cnt.
  - A repeat due in a cycle with s=1 is suppressed, but the schedule still advances.
  - Deasserting repeat_en stops repeats immediately. Reasserting it resumes on the running schedule.
  - A press_pulse is never high on two consecutive cycles, even when REPEAT_PERIOD=1.
- long_press: set on the edge where hold_cnt reaches LONG_CYCLES. It stays high until the release_pulse edge.
- Encoder: any_event and event_idx are combinational from the registered press_pulse vector, with no added latency. Lower index wins.
- Simultaneous events: multiple channels may pulse in the same cycle. press_pulse and release_pulse are never both high for the same channel.
- Reset mid-operation: pulses, held and long_press drop on the reset edge. The channel returns to INIT, needs a full DEBOUNCE_CYCLES released before re-arming, and emits no release_pulse.
- Power-up: a button already held at reset produces no press until it has been released for DEBOUNCE_CYCLES.

Test Plan:
All scenarios use CHANNELS=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, LONG_CYCLES=20.
1. Reset, button_n=4'hF for 6 cycles, then button_n[1]=0 sampled at edge N -> press_pulse=4'b0010 exactly from edge N+2 to N+3; held[1]=1; event_idx=1; any_event=1.
2. Channel 1 held, then bounce 1,0,1,1,0,1,1,1,1 -> no extra press_pulse. release_pulse[1] fires once, DEBOUNCE_CYCLES=4 cycles after the s-edge on which the final high run starts; held[1]=0.
3. repeat_en[0]=1, hold channel 0 for 30 cycles after its press pulse -> repeat pulses at hold_cnt 10, 15, 20, 25, 30; long_press[0]=1 from hold_cnt 20 until release_pulse.
4. Channels 2 and 3 pressed on the same edge -> press_pulse=4'b1100 on the same cycle; event_idx=2.
5. Button held through reset deassertion -> no press_pulse. After 4 released cycles plus a new press -> exactly one pulse.
6. Reset asserted while channel 0 is HELD with long_press=1 -> all outputs 0 on the next edge; no release_pulse ever emitted for that hold.
